// File: rtl/td4_prog_loader.sv
// rtl/td4_prog_loader.sv - loadable 16x8 program RAM with checksum-verified image load for td4
//
// Replaces the td4 fixed ROM. A byte stream (in_valid/in_ready) fills the RAM,
// an optional trailing checksum byte is verified, and the core is held in
// reset until a good image is present. Instruction fetch is combinational.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   load_start in   single-cycle pulse: begin or restart an image load
//   in_valid   in   in_data holds a byte
//   in_data    in   image byte (DEPTH data bytes, then checksum byte)
//   in_ready   out  loader accepts a byte this cycle (registered, state only)
//   adr        in   fetch address from the td4 PC
//   instr      out  mem[adr], combinational
//   cpu_reset  out  td4 reset; high whenever no verified image is running
//   loaded     out  a verified image is in memory
//   err        out  last load failed its checksum

module td4_prog_loader #(
    parameter int AW            = 4,
    parameter int DW            = 8,
    parameter int DEPTH         = 2**AW,
    parameter int USE_CHECKSUM  = 1,
    parameter int RELEASE_DELAY = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic [AW-1:0] adr,
    output logic [DW-1:0] instr,
    output logic          cpu_reset,
    output logic          loaded,
    output logic          err
);

    localparam int CW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_HOLD,
        S_RUN,
        S_ERROR
    } state_t;

    state_t          state;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [DW-1:0]   sum;
    logic [CW-1:0]   cnt;
    logic            accept;

    // in_ready is high only in LOAD/CHECK, so this is the handshake.
    assign accept = in_valid && in_ready;

    assign instr = mem[adr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state     <= S_IDLE;
            wptr      <= '0;
            sum       <= '0;
            cnt       <= '0;
            cpu_reset <= 1'b1;
            in_ready  <= 1'b0;
            loaded    <= 1'b0;
            err       <= 1'b0;
        end else if (load_start) begin
            // Restart from any state; a byte presented this cycle is dropped.
            state     <= S_LOAD;
            wptr      <= '0;
            sum       <= '0;
            cnt       <= '0;
            cpu_reset <= 1'b1;
            in_ready  <= 1'b1;
            loaded    <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        mem[wptr] <= in_data;
                        sum       <= sum + in_data;
                        if (wptr == AW'(DEPTH - 1)) begin
                            // wptr stays at the last word; no wrap.
                            if (USE_CHECKSUM != 0) begin
                                state <= S_CHECK;
                            end else begin
                                state    <= S_HOLD;
                                in_ready <= 1'b0;
                                cnt      <= '0;
                            end
                        end else begin
                            wptr <= wptr + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == sum) begin
                            state <= S_HOLD;
                            cnt   <= '0;
                        end else begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // Entered on edge N; release lands on edge N+RELEASE_DELAY.
                    if (cnt == CW'(RELEASE_DELAY - 1)) begin
                        state     <= S_RUN;
                        cpu_reset <= 1'b0;
                        loaded    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE, RUN, ERROR wait for load_start or reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_td4_prog_loader.sv
// tb/tb_td4_prog_loader.sv - self-checking bench for td4_prog_loader

module tb_td4_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] adr;
    logic [7:0] instr;
    logic       cpu_reset;
    logic       loaded;
    logic       err;

    td4_prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .adr        (adr),
        .instr      (instr),
        .cpu_reset  (cpu_reset),
        .loaded     (loaded),
        .err        (err)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference: what memory should hold, and the image being streamed.
    logic [7:0] model_mem [16];
    logic [7:0] img [16];

    typedef struct {
        logic [7:0] base;
        logic [7:0] csum;
        int         mode;       // 0: valid held high, 1: every other cycle, 2: random
        logic       exp_loaded;
        logic       exp_err;
        logic [3:0] probe;
        logic [7:0] exp_instr;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string name);
        for (int a = 0; a < 16; a++) begin
            adr = 4'(a);
            #1;
            check(name, instr, model_mem[a]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    endtask

    function automatic logic [7:0] img_sum();
        int s = 0;
        for (int i = 0; i < 16; i++) s += img[i];
        return 8'(s % 256);
    endfunction

    // Pulse load_start (with a junk byte that must be dropped), stream img plus
    // csum, then watch 6 more edges with in_valid still high.
    task automatic stream(input logic [7:0] csum, input int mode,
                          output int accepts, output int gap);
        logic [7:0] bytes [17];
        int idx = 0;
        int cyc = 0;
        logic hs;
        for (int i = 0; i < 16; i++) bytes[i] = img[i];
        bytes[16] = csum;
        accepts = 0;
        gap = -1;
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'hEE;
        step();
        load_start = 1'b0;
        while (idx < 17 && cyc < 200) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? bytes[idx] : 8'($urandom);
            hs = in_valid && in_ready;
            step();
            cyc++;
            if (hs) begin
                idx++;
                accepts++;
            end
        end
        if (idx < 17) $display("FAIL stream_timeout: got %0d bytes expected 17", idx);
        for (int i = 0; i < 16; i++) model_mem[i] = img[i];
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        check("ready_low_after_last", in_ready, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            hs = in_valid && in_ready;
            step();
            if (hs) accepts++;
            if (!cpu_reset && gap < 0) gap = k;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string name, input logic exp_loaded,
                                input logic exp_err, input int accepts, input int gap);
        check({name, "_accepts"}, accepts, 17);
        if (exp_loaded) check({name, "_release_gap"}, gap, 2);
        check({name, "_loaded"}, loaded, exp_loaded);
        check({name, "_err"}, err, exp_err);
        check({name, "_cpu_reset"}, cpu_reset, !exp_loaded);
    endtask

    initial begin
        int acc, gap;
        logic [7:0] cs;
        logic good;

        reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00; adr = 4'h0;
        model_reset();

        vecs[0] = '{8'h30, 8'h78, 0, 1'b1, 1'b0, 4'd5,  8'h35};
        vecs[1] = '{8'h30, 8'h77, 0, 1'b0, 1'b1, 4'd15, 8'h3F};
        vecs[2] = '{8'h30, 8'h78, 1, 1'b1, 1'b0, 4'd5,  8'h35};
        vecs[3] = '{8'h10, 8'h78, 2, 1'b1, 1'b0, 4'd6,  8'h16};
        vecs[4] = '{8'h00, 8'h77, 2, 1'b0, 1'b1, 4'd9,  8'h09};

        // Reset state
        step(); step();
        reset = 1'b0;
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_loaded", loaded, 1'b0);
        check("rst_err", err, 1'b0);
        check_mem("rst_mem");

        // Table-driven image loads
        foreach (vecs[v]) begin
            for (int i = 0; i < 16; i++) img[i] = vecs[v].base + 8'(i);
            stream(vecs[v].csum, vecs[v].mode, acc, gap);
            check_result($sformatf("vec%0d", v), vecs[v].exp_loaded, vecs[v].exp_err, acc, gap);
            adr = vecs[v].probe;
            #1;
            check($sformatf("vec%0d_probe", v), instr, vecs[v].exp_instr);
        end

        // Partial load of 7 bytes, then restart with a full good image
        load_start = 1'b1; step(); load_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 8'hA0 + 8'(i); step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) img[i] = 8'h10 + 8'(i);
        stream(8'h78, 0, acc, gap);
        check_result("restart", 1'b1, 1'b0, acc, gap);
        check_mem("restart_mem");

        // load_start while running drops loaded/cpu_reset on the same edge
        load_start = 1'b1; step(); load_start = 1'b0;
        check("relaunch_loaded", loaded, 1'b0);
        check("relaunch_cpu_reset", cpu_reset, 1'b1);
        check("relaunch_in_ready", in_ready, 1'b1);

        // Reset after 9 bytes clears everything, then a good load succeeds
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = 8'h55 + 8'(i); step();
        end
        in_valid = 1'b0;
        reset = 1'b1; step(); step(); reset = 1'b0;
        model_reset();
        check("midrst_cpu_reset", cpu_reset, 1'b1);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_loaded", loaded, 1'b0);
        check("midrst_err", err, 1'b0);
        check_mem("midrst_mem");
        for (int i = 0; i < 16; i++) img[i] = 8'h30 + 8'(i);
        stream(8'h78, 0, acc, gap);
        check_result("after_rst", 1'b1, 1'b0, acc, gap);

        // reset and load_start together: reset wins
        reset = 1'b1; load_start = 1'b1; step(); reset = 1'b0; load_start = 1'b0;
        model_reset();
        check("rst_wins_in_ready", in_ready, 1'b0);
        check("rst_wins_loaded", loaded, 1'b0);
        check("rst_wins_cpu_reset", cpu_reset, 1'b1);
        step();
        check("rst_wins_idle_ready", in_ready, 1'b0);
        check_mem("rst_wins_mem");

        // Randomized images against the reference model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
            good = 1'($urandom_range(0, 1));
            cs = good ? img_sum() : img_sum() + 8'($urandom_range(1, 255));
            stream(cs, 2, acc, gap);
            check_result($sformatf("rand%0d", r), good, !good, acc, gap);
            check_mem($sformatf("rand%0d_mem", r));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
